// File: rtl/lcd_pixel_feeder_if.sv
// Signal bundle between the LCD timing side, the SDRAM read FIFO and the pixel feeder.
// uflow_cnt exists only when LCD_FEED_UFLOW_CNT_EN is defined.
interface lcd_pixel_feeder_if;
    logic        lcd_vs;
    logic        data_req;
    logic        pad_req;
    logic [15:0] fifo_rd_data;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [15:0] pixel_data;
    logic        frame_start;
    logic        frame_done;
    logic        underflow;
    logic        frame_err;
`ifdef LCD_FEED_UFLOW_CNT_EN
    logic [15:0] uflow_cnt;

    modport slave (
        input  lcd_vs, data_req, pad_req, fifo_rd_data, fifo_empty,
        output fifo_rd_en, pixel_data, frame_start, frame_done, underflow, frame_err, uflow_cnt
    );
    modport master (
        output lcd_vs, data_req, pad_req, fifo_rd_data, fifo_empty,
        input  fifo_rd_en, pixel_data, frame_start, frame_done, underflow, frame_err, uflow_cnt
    );
`else
    modport slave (
        input  lcd_vs, data_req, pad_req, fifo_rd_data, fifo_empty,
        output fifo_rd_en, pixel_data, frame_start, frame_done, underflow, frame_err
    );
    modport master (
        output lcd_vs, data_req, pad_req, fifo_rd_data, fifo_empty,
        input  fifo_rd_en, pixel_data, frame_start, frame_done, underflow, frame_err
    );
`endif
endinterface

// File: rtl/lcd_pixel_feeder.sv
// Feeds RGB565 pixels from the SDRAM read FIFO to the LCD driver, one frame per vsync.
// Optional underflow counter enabled by defining LCD_FEED_UFLOW_CNT_EN.
module lcd_pixel_feeder #(
    parameter logic [19:0] FRAME_PIX  = 20'd307200,
    parameter logic [19:0] PAD_PIX    = 20'd0,
    parameter logic [15:0] FILL_COLOR = 16'h0000
) (
    input  logic lcd_pclk,
    input  logic rst_n,
    lcd_pixel_feeder_if.slave bus
);

    localparam logic [1:0] S_WAIT_VS = 2'd0;
    localparam logic [1:0] S_ACTIVE  = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    // One extra bit so FRAME_PIX+PAD_PIX cannot overflow the comparison.
    localparam logic [20:0] TOTAL_PIX = {1'b0, FRAME_PIX} + {1'b0, PAD_PIX};

    logic [1:0]  state;
    logic [19:0] pix_cnt;
    logic        vs_d1;
    logic        rd_d1;
    logic        vs_rise;
    logic        in_data;
    logic        consume;
    logic [20:0] cnt_nxt;

    assign vs_rise = bus.lcd_vs & ~vs_d1;
    assign in_data = (pix_cnt < FRAME_PIX);
    assign cnt_nxt = {1'b0, pix_cnt} + 21'd1;

    // A restart always wins over a request in the same cycle, so no word is consumed then.
    assign consume = (state == S_ACTIVE) & ~vs_rise & ({1'b0, pix_cnt} < TOTAL_PIX) &
                     ((bus.data_req & in_data) | (bus.pad_req & ~in_data));

    assign bus.fifo_rd_en = consume & ~bus.fifo_empty;
    assign bus.pixel_data = rd_d1 ? bus.fifo_rd_data : FILL_COLOR;
    assign bus.frame_done = (state == S_DONE);

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_WAIT_VS;
            pix_cnt         <= 20'd0;
            vs_d1           <= 1'b0;
            rd_d1           <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.underflow   <= 1'b0;
            bus.frame_err   <= 1'b0;
        end else begin
            vs_d1           <= bus.lcd_vs;
            rd_d1           <= bus.fifo_rd_en & in_data;
            bus.frame_start <= vs_rise;
            if (vs_rise) begin
                state         <= S_ACTIVE;
                pix_cnt       <= 20'd0;
                bus.underflow <= 1'b0;
                bus.frame_err <= (state == S_ACTIVE) && ({1'b0, pix_cnt} < TOTAL_PIX);
            end else begin
                // Empty-FIFO requests still advance the count to keep the frame aligned.
                if (consume) begin
                    pix_cnt <= cnt_nxt[19:0];
                    if (bus.fifo_empty)
                        bus.underflow <= 1'b1;
                end
                if ((state == S_ACTIVE) &&
                    ((consume && (cnt_nxt >= TOTAL_PIX)) || ({1'b0, pix_cnt} >= TOTAL_PIX)))
                    state <= S_DONE;
            end
        end
    end

`ifdef LCD_FEED_UFLOW_CNT_EN
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n)
            bus.uflow_cnt <= 16'd0;
        else if (vs_rise)
            bus.uflow_cnt <= 16'd0;
        else if (consume && bus.fifo_empty && (bus.uflow_cnt != 16'hFFFF))
            bus.uflow_cnt <= bus.uflow_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_lcd_pixel_feeder.sv
// Table-driven bench for lcd_pixel_feeder with a pixel scoreboard and a simple FIFO model.
// Saturation of the underflow counter is exercised only when LCD_FEED_UFLOW_CNT_EN is defined.
module tb_lcd_pixel_feeder;

    localparam logic [15:0] FILL = 16'h0000;

    typedef struct {
        logic        vs, dreq, preq, empty;
        logic        rd;
        logic [15:0] pix;
        logic        done, uf, fe, fs;
        logic [15:0] uc;
        logic [19:0] cnt;
    } vec_t;

    logic lcd_pclk = 1'b0;
    logic rst_n    = 1'b0;
    int   n_vec    = 0;
    int   n_err    = 0;
    int   rd_ptr   = 0;
    int   cur_row  = 0;
    logic [15:0] w = 16'd1;
    vec_t vecs[$];
    logic [15:0] exp_q[$];

    always #5 lcd_pclk = ~lcd_pclk;

    lcd_pixel_feeder_if bus ();

    lcd_pixel_feeder #(.FRAME_PIX(20'd16), .PAD_PIX(20'd2), .FILL_COLOR(FILL)) dut (
        .lcd_pclk (lcd_pclk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    // Normal-mode FIFO: q shows word N+1 the cycle after the Nth read strobe.
    always @(posedge lcd_pclk) begin
        if (bus.fifo_rd_en) begin
            bus.fifo_rd_data <= 16'(rd_ptr + 1);
            rd_ptr           <= rd_ptr + 1;
        end
    end

`ifdef LCD_FEED_UFLOW_CNT_EN
    logic rst2_n = 1'b0;
    lcd_pixel_feeder_if bus2 ();
    lcd_pixel_feeder #(.FRAME_PIX(20'd100000), .PAD_PIX(20'd0), .FILL_COLOR(FILL)) dut2 (
        .lcd_pclk (lcd_pclk),
        .rst_n    (rst2_n),
        .bus      (bus2)
    );
`endif

    function automatic void addRow(logic vs, logic dreq, logic preq, logic empty, logic rd,
                                   logic [15:0] pix, logic done, logic uf, logic fe, logic fs,
                                   logic [15:0] uc, logic [19:0] cnt);
        vec_t v;
        v.vs = vs; v.dreq = dreq; v.preq = preq; v.empty = empty; v.rd = rd; v.pix = pix;
        v.done = done; v.uf = uf; v.fe = fe; v.fs = fs; v.uc = uc; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("[TB] FAIL %s row %0d: got %0h, expected %0h", name, cur_row, act, expv);
        end
    endtask

    // Drive one row, check outputs after settling, then advance to just past the next edge.
    task automatic applyStimulus(input vec_t v);
        logic [15:0] e;
        bus.lcd_vs     = v.vs;
        bus.data_req   = v.dreq;
        bus.pad_req    = v.preq;
        bus.fifo_empty = v.empty;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("pixel_data", 32'(bus.pixel_data), 32'(e));
        end
        checkOutput("fifo_rd_en",  32'(bus.fifo_rd_en),  32'(v.rd));
        checkOutput("frame_done",  32'(bus.frame_done),  32'(v.done));
        checkOutput("underflow",   32'(bus.underflow),   32'(v.uf));
        checkOutput("frame_err",   32'(bus.frame_err),   32'(v.fe));
        checkOutput("frame_start", 32'(bus.frame_start), 32'(v.fs));
        checkOutput("pix_cnt",     32'(dut.pix_cnt),     32'(v.cnt));
`ifdef LCD_FEED_UFLOW_CNT_EN
        checkOutput("uflow_cnt",   32'(bus.uflow_cnt),   32'(v.uc));
`endif
        exp_q.push_back(v.pix);
        cur_row++;
        @(posedge lcd_pclk);
        #1;
    endtask

    initial begin
        vec_t r;
        bus.lcd_vs = 1'b0; bus.data_req = 1'b0; bus.pad_req = 1'b0;
        bus.fifo_empty = 1'b0; bus.fifo_rd_data = 16'h0;

        // Frame 1: data before the first vsync, vsync coinciding with a request, full frame + pad.
        addRow(0,0,0,0, 0,FILL, 0,0,0,0, 16'd0, 20'd0);
        addRow(0,1,0,0, 0,FILL, 0,0,0,0, 16'd0, 20'd0);
        addRow(1,1,0,0, 0,FILL, 0,0,0,0, 16'd0, 20'd0);
        for (int i = 0; i < 16; i++) begin
            addRow(0,1,0,0, 1,w, 0,0,0,(i == 0), 16'd0, 20'(i)); w++;
        end
        for (int i = 0; i < 2; i++) begin
            addRow(0,0,1,0, 1,FILL, 0,0,0,0, 16'd0, 20'(16 + i)); w++;
        end
        addRow(0,0,0,0, 0,FILL, 1,0,0,0, 16'd0, 20'd18);
        addRow(0,1,0,0, 0,FILL, 1,0,0,0, 16'd0, 20'd18);
        addRow(0,0,1,0, 0,FILL, 1,0,0,0, 16'd0, 20'd18);
        // Frame 2: empty FIFO on the 5th request, then a short frame cut by vsync.
        addRow(1,0,0,0, 0,FILL, 1,0,0,0, 16'd0, 20'd18);
        for (int k = 0; k < 4; k++) begin
            addRow(0,1,0,0, 1,w, 0,0,0,(k == 0), 16'd0, 20'(k)); w++;
        end
        addRow(0,1,0,1, 0,FILL, 0,0,0,0, 16'd0, 20'd4);
        for (int j = 0; j < 5; j++) begin
            addRow(0,1,0,0, 1,w, 0,1,0,0, 16'd1, 20'(5 + j)); w++;
        end
        addRow(1,1,0,0, 0,FILL, 0,1,0,0, 16'd1, 20'd10);
        addRow(0,0,0,0, 0,FILL, 0,0,1,1, 16'd0, 20'd0);
        // Frame 3: misplaced pad/data requests are ignored; frame_err clears on a clean restart.
        for (int i = 0; i < 16; i++) begin
            if (i == 3) addRow(0,0,1,0, 0,FILL, 0,0,1,0, 16'd0, 20'd3);
            addRow(0,1,0,0, 1,w, 0,0,1,0, 16'd0, 20'(i)); w++;
        end
        addRow(0,1,0,0, 0,FILL, 0,0,1,0, 16'd0, 20'd16);
        for (int i = 0; i < 2; i++) begin
            addRow(0,0,1,0, 1,FILL, 0,0,1,0, 16'd0, 20'(16 + i)); w++;
        end
        addRow(0,0,0,0, 0,FILL, 1,0,1,0, 16'd0, 20'd18);
        addRow(1,0,0,0, 0,FILL, 1,0,1,0, 16'd0, 20'd18);
        addRow(0,0,0,0, 0,FILL, 0,0,0,1, 16'd0, 20'd0);

        // Reset values.
        repeat (2) @(posedge lcd_pclk);
        #1;
        checkOutput("rst_pixel_data", 32'(bus.pixel_data), 32'(FILL));
        checkOutput("rst_fifo_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        checkOutput("rst_frame_done", 32'(bus.frame_done), 32'd0);
        checkOutput("rst_frame_start", 32'(bus.frame_start), 32'd0);
        rst_n = 1'b1;
        @(posedge lcd_pclk);
        #1;

        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(vecs[i]);

        // Reset at pix_cnt=7 with a valid pixel on the output and underflow set.
        r = '{vs:0, dreq:1, preq:0, empty:1, rd:0, pix:FILL, done:0, uf:0, fe:0, fs:0, uc:16'd0, cnt:20'd0};
        applyStimulus(r);
        for (int i = 0; i < 6; i++) begin
            r = '{vs:0, dreq:1, preq:0, empty:0, rd:1, pix:w, done:0, uf:1, fe:0, fs:0, uc:16'd1, cnt:20'(1 + i)};
            applyStimulus(r);
            w++;
        end
        bus.data_req = 1'b1;
        rst_n        = 1'b0;
        #1;
        exp_q.delete();
        checkOutput("mid_rst_pixel_data", 32'(bus.pixel_data), 32'(FILL));
        checkOutput("mid_rst_fifo_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        checkOutput("mid_rst_underflow",  32'(bus.underflow),  32'd0);
        checkOutput("mid_rst_frame_done", 32'(bus.frame_done), 32'd0);
        checkOutput("mid_rst_pix_cnt",    32'(dut.pix_cnt),    32'd0);
`ifdef LCD_FEED_UFLOW_CNT_EN
        checkOutput("mid_rst_uflow_cnt",  32'(bus.uflow_cnt),  32'd0);
`endif
        @(posedge lcd_pclk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            r = '{vs:0, dreq:1, preq:0, empty:0, rd:0, pix:FILL, done:0, uf:0, fe:0, fs:0, uc:16'd0, cnt:20'd0};
            applyStimulus(r);
        end
        r = '{vs:1, dreq:0, preq:0, empty:0, rd:0, pix:FILL, done:0, uf:0, fe:0, fs:0, uc:16'd0, cnt:20'd0};
        applyStimulus(r);
        r = '{vs:0, dreq:1, preq:0, empty:0, rd:1, pix:w, done:0, uf:0, fe:0, fs:1, uc:16'd0, cnt:20'd0};
        applyStimulus(r);
        w++;
        r = '{vs:0, dreq:0, preq:0, empty:0, rd:0, pix:FILL, done:0, uf:0, fe:0, fs:0, uc:16'd0, cnt:20'd1};
        applyStimulus(r);

        checkOutput("fifo_read_total", 32'(rd_ptr), 32'(w - 16'd1));

`ifdef LCD_FEED_UFLOW_CNT_EN
        bus2.lcd_vs = 1'b0; bus2.data_req = 1'b0; bus2.pad_req = 1'b0;
        bus2.fifo_empty = 1'b1; bus2.fifo_rd_data = 16'h0;
        rst2_n = 1'b1;
        @(posedge lcd_pclk);
        #1;
        bus2.lcd_vs = 1'b1;
        @(posedge lcd_pclk);
        #1;
        bus2.lcd_vs   = 1'b0;
        bus2.data_req = 1'b1;
        repeat (70000) @(posedge lcd_pclk);
        #1;
        bus2.data_req = 1'b0;
        checkOutput("uflow_cnt_sat", 32'(bus2.uflow_cnt), 32'h0000FFFF);
        checkOutput("uflow_sat_underflow", 32'(bus2.underflow), 32'd1);
        checkOutput("uflow_sat_rd_en_count", 32'(dut2.pix_cnt), 32'd70000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
